gray_ptr_decoder: RTL

Registered Gray-to-binary receiver for a Gray-coded position or pointer driven from outside the `clk` domain, such as an async FIFO pointer or an encoder count. Structure:
- a synchronizer chain on the Gray bus;
- conversion to binary;
- per-cycle step classification against the last accepted value: hold, up, down, wrap or illegal jump;
- a saturating error counter.

It is the receive-side counterpart of the binary-to-Gray encoder that generates such buses.

---
 rtl/gray_ptr_decoder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gray_ptr_decoder.sv
// Registered Gray-to-binary receiver with synchronizer, step classification and
// saturating error counter. Define GRAY_DEC_DIR_EN to generate up/down/wrap pulses.
module gray_ptr_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             up,
    output logic             down,
    output logic             wrap,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0]    ACQ_LAST = CW'(SYNC_STAGES);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL1     = {WIDTH{1'b1}};

    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t                             state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_r;
    logic [CW-1:0]                      acq_cnt_r, acq_cnt_nxt_s;
    logic [WIDTH-1:0]                   g_s, b_s, d_s;
    logic [WIDTH-1:0]                   bin_r, bin_nxt_s;
    logic                               valid_r, valid_nxt_s;
    logic                               err_r, err_nxt_s;
    logic [7:0]                         err_cnt_r, err_cnt_nxt_s;

    assign g_s = sync_r[SYNC_STAGES-1];
    assign b_s = gray2bin(g_s);
    assign d_s = b_s - bin_r;

    // Synchronizer chain on the asynchronous Gray bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '{default: {WIDTH{1'b0}}};
        end else begin
            sync_r[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Next-state and accepted-value logic; only TRACK classifies steps
    always_comb begin
        state_nxt_s   = state_r;
        acq_cnt_nxt_s = acq_cnt_r;
        bin_nxt_s     = bin_r;
        valid_nxt_s   = valid_r;
        err_nxt_s     = 1'b0;
        case (state_r)
            ST_ACQ: begin
                if (acq_cnt_r == ACQ_LAST) begin
                    bin_nxt_s     = b_s;
                    valid_nxt_s   = 1'b1;
                    acq_cnt_nxt_s = CNT_ZERO;
                    state_nxt_s   = ST_TRACK;
                end else begin
                    acq_cnt_nxt_s = acq_cnt_r + CNT_ONE;
                end
            end
            ST_TRACK: begin
                bin_nxt_s = b_s;
                err_nxt_s = !((d_s == ZERO) || (d_s == ONE) || (d_s == ALL1));
            end
            default: begin
                state_nxt_s   = ST_ACQ;
                acq_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Saturating error counter; a clear overrides a coincident increment
    always_comb begin
        if (clr_err) begin
            err_cnt_nxt_s = 8'd0;
        end else if (err_nxt_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // FSM state, accepted value and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_ACQ;
            acq_cnt_r <= CNT_ZERO;
            bin_r     <= ZERO;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            acq_cnt_r <= acq_cnt_nxt_s;
            bin_r     <= bin_nxt_s;
            valid_r   <= valid_nxt_s;
            err_r     <= err_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

`ifdef GRAY_DEC_DIR_EN
    logic up_r, down_r, wrap_r;
    logic up_nxt_s, down_nxt_s, wrap_nxt_s;

    // Direction classification; wrap marks crossing between all-ones and zero
    always_comb begin
        up_nxt_s   = 1'b0;
        down_nxt_s = 1'b0;
        wrap_nxt_s = 1'b0;
        if (state_r == ST_TRACK) begin
            up_nxt_s   = (d_s == ONE);
            down_nxt_s = (d_s == ALL1);
            wrap_nxt_s = (up_nxt_s && (bin_r == ALL1)) || (down_nxt_s && (bin_r == ZERO));
        end else begin
            up_nxt_s   = 1'b0;
            down_nxt_s = 1'b0;
            wrap_nxt_s = 1'b0;
        end
    end

    // Direction pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_r   <= 1'b0;
            down_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            up_r   <= up_nxt_s;
            down_r <= down_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign up   = up_r;
    assign down = down_r;
    assign wrap = wrap_r;
`else
    assign up   = 1'b0;
    assign down = 1'b0;
    assign wrap = 1'b0;
`endif

    assign bin_out   = bin_r;
    assign bin_valid = valid_r;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule
